if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- PC register and instruction-fetch front end of the 5-stage MIPS pipeline.
- Directly upstream of npc: supplies PC to npc and loads npc's NPC on advance or redirect.
- Drives the instruction SRAM-like bus (req/addr_ok/data_ok).
- Holds one fetched instruction in a buffer until IF/ID accepts it, and cancels in-flight fetches on flush.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- NPC  in  32  next PC from npc.
- PCWr  in  1  pipeline advance enable from hazard unit; 0 = hold.
- IF_Flush  in  1  redirect/flush from npc.
- inst_req  out  1  fetch request valid.
- inst_addr  out  32  fetch address, always equals PC.
- inst_addr_ok  in  1  bus accepted the request this cycle (meaningful only while inst_req=1).
- inst_data_ok  in  1  read data valid this cycle.
- inst_rdata  in  32  instruction word.
- PC  out  32  current fetch PC, feeds npc.
- if_valid  out  1  if_instr/if_pc hold a valid instruction for IF/ID.
- if_pc  out  32  PC of the buffered instruction.
- if_instr  out  32  buffered instruction word.
- fetch_stall  out  1  to hazard unit: no instruction ready (= !if_valid).
- if_adel  out  1  buffered slot carries an address-error exception (only with the optional feature; tied 0 otherwise).

Behaviour:
- Reset values:
  - PC = RESET_PC; state = REQ.
  - inst_req = 0 during the reset cycle, 1 from the first cycle after.
  - if_valid = 0, if_pc = RESET_PC, if_instr = 0, if_adel = 0; fetch_stall = 1.
- States:
  - REQ: inst_req = 1, inst_addr = PC.
  - WAIT: request accepted, awaiting data.
  - FULL: buffer valid, no request outstanding.
  - CANCEL: awaiting data_ok for a flushed request; the data is discarded.
- REQ:
  - addr_ok = 1 → WAIT.
  - The address may change while in REQ before acceptance.
- WAIT:
  - data_ok = 1 → if_instr <= inst_rdata, if_pc <= PC, if_valid <= 1, → FULL.
  - Data is visible to ID the next cycle, so the minimum fetch latency is req→addr_ok→data_ok plus 1 cycle.
- FULL:
  - PCWr = 1 → PC <= NPC, if_valid <= 0, → REQ.
  - PCWr = 0 → hold everything.
- Flush (IF_Flush = 1, priority over every other transition):
  - PC <= NPC, if_valid <= 0, if_adel <= 0.
  - From REQ with addr_ok = 1 this cycle, or from WAIT with data_ok = 0 → CANCEL.
  - From WAIT with data_ok = 1 → REQ (that data is dropped).
  - From REQ (not accepted), FULL or CANCEL → REQ; CANCEL stays CANCEL unless data_ok arrives the same cycle, in which case → REQ.
- CANCEL:
  - inst_req = 0.
  - data_ok = 1 → REQ; the data is never written to the buffer.
- At most one outstanding request; no second req before data_ok.
- PCWr = 0 in REQ/WAIT/CANCEL has no effect; only the buffer handoff waits on PCWr.
- PC increments are npc's responsibility; this block never computes PC+4.
- Reset mid-transaction returns to the reset state; any late data_ok after reset is ignored only if it arrives in CANCEL. The bus is reset together with this block, so none arrives.

Optional Feature:
- Macro: IF_ADEL_CHECK_EN.
- Defined:
  - In REQ with PC[1:0] != 0: inst_req = 0, no bus request is issued.
  - Next cycle: if_valid = 1, if_adel = 1, if_pc = PC, if_instr = 0, → FULL.
  - The slot flows down as an exception carrier.
- Undefined: if_adel is constant 0 and the low address bits are passed unchecked.

Decomposition:
- Shared package: fetch state encoding (REQ, WAIT, FULL, CANCEL, 2 bits), RESET_PC constant, exception entry 32'hBFC0_0380 for the verification reference model.
- Optional single sub-module fetch_buf holding if_valid/if_pc/if_instr/if_adel with load/clear controls; the FSM stays in the top.

Test Plan:
1. Reset then addr_ok=1 at cycle 1 and data_ok=1 with rdata=0x2408_0001 at cycle 3 → if_valid=1, if_pc=0xBFC0_0000 at cycle 4; PCWr=1, NPC=0xBFC0_0004 → PC=0xBFC0_0004, inst_req=1 next cycle.
2. FULL with PCWr=0 for 5 cycles → if_instr/if_pc/PC stable, inst_req=0, fetch_stall=0.
3. WAIT then IF_Flush with NPC=0xBFC0_0380, followed by data_ok two cycles later with 0xDEAD_BEEF → data discarded, if_valid never 1 for it, next request at 0xBFC0_0380.
4. Flush in the same cycle as data_ok in WAIT → data dropped, state REQ, inst_addr=NPC next cycle.
5. Flush in REQ same cycle as addr_ok → CANCEL; subsequent data_ok ignored; then a fresh request at NPC.
6. (IF_ADEL_CHECK_EN) NPC=0xBFC0_0002 loaded → no inst_req, next cycle if_valid=1, if_adel=1, if_pc=0xBFC0_0002.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_fetch_stage_pkg;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,   // request on the bus, waiting for addr_ok
        ST_WAIT   = 2'd1,   // request accepted, waiting for data_ok
        ST_FULL   = 2'd2,   // buffer holds an instruction, bus idle
        ST_CANCEL = 2'd3    // flushed request still in flight, data dropped
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] FETCH_EXC_ENTRY = 32'hBFC0_0380;

    // Word-aligned fetch addresses only
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_stage_fetch_buf.sv
// One-entry holding buffer for the fetched instruction handed to IF/ID.
// Latency: loaded value visible the cycle after load.
// Backpressure: holds its contents until the owner pulses clear.
module fetch_buf
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    input  logic        load_adel,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_adel
);

    // Slot register: clear wins over load, pc/instr keep their last value on clear
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
            if_instr <= 32'h0;
            if_adel  <= 1'b0;
        end else if (clear) begin
            if_valid <= 1'b0;
            if_adel  <= 1'b0;
        end else if (load) begin
            if_valid <= 1'b1;
            if_pc    <= load_pc;
            if_instr <= load_instr;
            if_adel  <= load_adel;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// PC register + instruction fetch FSM driving an SRAM-like req/addr_ok/data_ok bus.
// Latency: req->addr_ok->data_ok, then instruction valid to ID one cycle later.
// Backpressure: one request in flight; buffered instruction held until PCWr. Optional: IF_ADEL_CHECK_EN.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] NPC,
    input  logic        PCWr,
    input  logic        IF_Flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] PC,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_stall,
    output logic        if_adel
);

    fetch_state_t state, state_nxt;
    logic         pc_ok;
    logic         req_fire;
    logic         pc_ld;
    logic         buf_load;
    logic         buf_clear;
    logic         buf_adel;
    logic [31:0]  buf_instr;

`ifdef IF_ADEL_CHECK_EN
    // A misaligned PC never reaches the bus; it becomes an exception slot instead
    assign pc_ok = !pc_misaligned(PC);
`else
    assign pc_ok = 1'b1;
`endif

    assign inst_req    = !rst && (state == ST_REQ) && pc_ok;
    assign inst_addr   = PC;
    assign req_fire    = inst_req && inst_addr_ok;
    assign fetch_stall = !if_valid;

    // State and PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_REQ;
            PC    <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (pc_ld) begin
                PC <= NPC;
            end
        end
    end

    // Next-state and buffer/PC controls; flush overrides every other transition
    always_comb begin
        state_nxt = state;
        pc_ld     = 1'b0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        buf_adel  = 1'b0;
        buf_instr = inst_rdata;
        if (IF_Flush) begin
            pc_ld     = 1'b1;
            buf_clear = 1'b1;
            case (state)
                ST_REQ:    state_nxt = req_fire ? ST_CANCEL : ST_REQ;
                ST_WAIT,
                ST_CANCEL: state_nxt = inst_data_ok ? ST_REQ : ST_CANCEL;
                default:   state_nxt = ST_REQ;
            endcase
        end else begin
            case (state)
                ST_REQ: begin
                    if (!pc_ok) begin
                        buf_load  = 1'b1;
                        buf_adel  = 1'b1;
                        buf_instr = 32'h0;
                        state_nxt = ST_FULL;
                    end else if (req_fire) begin
                        state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        buf_load  = 1'b1;
                        state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (PCWr) begin
                        pc_ld     = 1'b1;
                        buf_clear = 1'b1;
                        state_nxt = ST_REQ;
                    end
                end
                ST_CANCEL: begin
                    if (inst_data_ok) begin
                        state_nxt = ST_REQ;
                    end
                end
                default: state_nxt = ST_REQ;
            endcase
        end
    end

    fetch_buf #(
        .RESET_PC (RESET_PC)
    ) u_fetch_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_pc    (PC),
        .load_instr (buf_instr),
        .load_adel  (buf_adel),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_adel    (if_adel)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized + directed bench for if_fetch_stage against a transaction-level model.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] NPC;
    logic        PCWr;
    logic        IF_Flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] PC;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_stall;
    logic        if_adel;

    if_fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .NPC          (NPC),
        .PCWr         (PCWr),
        .IF_Flush     (IF_Flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .PC           (PC),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .fetch_stall  (fetch_stall),
        .if_adel      (if_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: PC, one-slot buffer, and the in-flight request
    logic [31:0] m_pc;
    logic        m_bv;
    logic [31:0] m_bpc;
    logic [31:0] m_binstr;
    logic        m_badel;
    logic        m_outst;     // a request has been accepted and its data is still due
    logic        m_disc;      // that data belongs to a flushed fetch
    logic        started = 1'b0;

    // Bench-side bus for the random phase
    logic        bus_pend;
    logic [31:0] bus_addr;
    int          bus_delay;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2408_0000;
    endfunction

    function automatic logic m_aligned_ok();
`ifdef IF_ADEL_CHECK_EN
        return m_pc[1:0] == 2'b00;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic m_req(input logic r);
        return !r && !m_bv && !m_outst && m_aligned_ok();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare against model, advance model at the edge
    task automatic step(input logic r, input logic pw, input logic fl,
                        input logic aok, input logic dok,
                        input logic [31:0] npc_i, input logic [31:0] rd);
        logic [31:0] n_pc, n_bpc, n_binstr;
        logic        n_bv, n_badel, n_outst, n_disc, fire;
        @(negedge clk);
        rst = r; PCWr = pw; IF_Flush = fl; inst_addr_ok = aok;
        inst_data_ok = dok; NPC = npc_i; inst_rdata = rd;
        #1;
        if (started) begin
            chk("inst_req", {31'h0, inst_req}, {31'h0, m_req(r)});
            chk("inst_addr", inst_addr, m_pc);
            chk("pc", PC, m_pc);
            chk("if_valid", {31'h0, if_valid}, {31'h0, m_bv});
            chk("fetch_stall", {31'h0, fetch_stall}, {31'h0, !m_bv});
            if (m_bv) begin
                chk("if_pc", if_pc, m_bpc);
                chk("if_instr", if_instr, m_binstr);
                chk("if_adel", {31'h0, if_adel}, {31'h0, m_badel});
            end
        end
        n_pc = m_pc; n_bv = m_bv; n_bpc = m_bpc; n_binstr = m_binstr;
        n_badel = m_badel; n_outst = m_outst; n_disc = m_disc;
        fire = m_req(r) && aok;
        if (r) begin
            n_pc = FETCH_RESET_PC; n_bv = 0; n_bpc = FETCH_RESET_PC;
            n_binstr = 0; n_badel = 0; n_outst = 0; n_disc = 0;
        end else if (fl) begin
            n_pc = npc_i; n_bv = 0; n_badel = 0;
            if (fire || (m_outst && !dok)) begin
                n_outst = 1; n_disc = 1;
            end else begin
                n_outst = 0; n_disc = 0;
            end
        end else if (m_outst) begin
            if (dok) begin
                n_outst = 0; n_disc = 0;
                if (!m_disc) begin
                    n_bv = 1; n_bpc = m_pc; n_binstr = rd; n_badel = 0;
                end
            end
        end else if (m_bv) begin
            if (pw) begin
                n_pc = npc_i; n_bv = 0; n_badel = 0;
            end
        end else if (!m_aligned_ok()) begin
            n_bv = 1; n_badel = 1; n_bpc = m_pc; n_binstr = 0;
        end else if (fire) begin
            n_outst = 1;
        end
        @(posedge clk);
        m_pc = n_pc; m_bv = n_bv; m_bpc = n_bpc; m_binstr = n_binstr;
        m_badel = n_badel; m_outst = n_outst; m_disc = n_disc;
        if (r) started = 1'b1;
        #1;
    endtask

    initial begin
        logic        r, pw, fl, aok, dok;
        logic [31:0] npc_v, rd;
        rst = 1; NPC = 0; PCWr = 0; IF_Flush = 0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
        m_pc = FETCH_RESET_PC; m_bv = 0; m_bpc = FETCH_RESET_PC; m_binstr = 0;
        m_badel = 0; m_outst = 0; m_disc = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("rst_pc", PC, 32'hBFC0_0000);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_stall", {31'h0, fetch_stall}, 32'h1);
        chk("rst_if_pc", if_pc, 32'hBFC0_0000);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_adel", {31'h0, if_adel}, 32'h0);
        chk("rst_req", {31'h0, inst_req}, 32'h0);

        // Basic fetch: addr_ok at cycle 1, data_ok at cycle 3
        step(0, 0, 0, 1, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h0, 32'h2408_0001);
        chk("t1_valid", {31'h0, if_valid}, 32'h1);
        chk("t1_if_pc", if_pc, 32'hBFC0_0000);
        chk("t1_instr", if_instr, 32'h2408_0001);

        // Hold in FULL
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 32'h1234_5678, 32'h0);
        chk("t2_instr", if_instr, 32'h2408_0001);
        chk("t2_pc", PC, 32'hBFC0_0000);
        chk("t2_req", {31'h0, inst_req}, 32'h0);
        chk("t2_stall", {31'h0, fetch_stall}, 32'h0);

        // Advance
        step(0, 1, 0, 0, 0, 32'hBFC0_0004, 32'h0);
        chk("t1_pc_adv", PC, 32'hBFC0_0004);
        chk("t1_req_adv", {31'h0, inst_req}, 32'h1);

        // Flush while waiting; late data discarded
        step(0, 0, 0, 1, 0, 32'h0, 32'h0);
        step(0, 0, 1, 0, 0, FETCH_EXC_ENTRY, 32'h0);
        chk("t3_req_cancel", {31'h0, inst_req}, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h0, 32'hDEAD_BEEF);
        chk("t3_valid", {31'h0, if_valid}, 32'h0);
        chk("t3_req", {31'h0, inst_req}, 32'h1);
        chk("t3_addr", inst_addr, 32'hBFC0_0380);

        // Flush coinciding with data_ok
        step(0, 0, 0, 1, 0, 32'h0, 32'h0);
        step(0, 0, 1, 0, 1, 32'hBFC0_0400, 32'hDEAD_BEEF);
        chk("t4_valid", {31'h0, if_valid}, 32'h0);
        chk("t4_req", {31'h0, inst_req}, 32'h1);
        chk("t4_addr", inst_addr, 32'hBFC0_0400);

        // Flush coinciding with addr_ok
        step(0, 0, 1, 1, 0, 32'hBFC0_0500, 32'h0);
        chk("t5_req_cancel", {31'h0, inst_req}, 32'h0);
        step(0, 0, 0, 0, 1, 32'h0, 32'hDEAD_BEEF);
        chk("t5_valid", {31'h0, if_valid}, 32'h0);
        chk("t5_addr", inst_addr, 32'hBFC0_0500);
        step(0, 0, 0, 1, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h0, 32'h1111_2222);
        chk("t5_instr", if_instr, 32'h1111_2222);
        chk("t5_if_pc", if_pc, 32'hBFC0_0500);

`ifdef IF_ADEL_CHECK_EN
        // Misaligned PC becomes an exception slot
        step(0, 1, 0, 0, 0, 32'hBFC0_0002, 32'h0);
        chk("t6_req", {31'h0, inst_req}, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("t6_valid", {31'h0, if_valid}, 32'h1);
        chk("t6_adel", {31'h0, if_adel}, 32'h1);
        chk("t6_if_pc", if_pc, 32'hBFC0_0002);
        chk("t6_instr", if_instr, 32'h0);
        step(0, 1, 0, 0, 0, 32'hBFC0_0008, 32'h0);
        chk("t6_adel_clr", {31'h0, if_adel}, 32'h0);
`endif

        // Random phase with a legal bus model
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);
        bus_pend = 0; bus_addr = 0; bus_delay = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] cur_pc;
            r     = ($urandom % 200) == 0;
            fl    = ($urandom % 12) == 0;
            pw    = $urandom % 2;
            npc_v = 32'hBFC0_0000 | ($urandom & 32'h0000_FFFC);
            if (($urandom % 16) == 0) npc_v[1:0] = 2'($urandom % 4);
            aok   = m_req(r) && ($urandom % 2);
            dok   = !r && bus_pend && (bus_delay == 0);
            rd    = dok ? mem_word(bus_addr) : $urandom;
            cur_pc = m_pc;
            step(r, pw, fl, aok, dok, npc_v, rd);
            if (r) begin
                bus_pend = 0;
            end else begin
                if (dok) bus_pend = 0;
                else if (bus_pend) bus_delay--;
                if (aok) begin
                    bus_pend  = 1;
                    bus_addr  = cur_pc;
                    bus_delay = $urandom % 3;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
